// File: rtl/ycbcr_pkg.sv
// Constants shared by the RGB565<->YCbCr converters (BT.601 full range, x256).
package ycbcr_pkg;
  localparam int C_R_CR   = 359;
  localparam int C_G_CB   = 88;
  localparam int C_G_CR   = 183;
  localparam int C_B_CB   = 454;
  localparam int C_OFFSET = 128;
  localparam int C_SHIFT  = 8;
  localparam int C_RND    = 128;

  localparam int W_PROD = 18;
  localparam int W_RES  = 11;

  // Signed 9-bit chroma times an unsigned coefficient; |result| <= 454*128 fits 18 bits.
  function automatic logic signed [W_PROD-1:0] mul_coef(input logic signed [8:0] x,
                                                         input int c);
    logic signed [W_PROD-1:0] xe;
    logic signed [W_PROD-1:0] ce;
    xe = {{(W_PROD-9){x[8]}}, x};
    ce = W_PROD'(c);
    return xe * ce;
  endfunction
endpackage

// File: rtl/ycbcr_rgb565_sat_u8.sv
// Clamp an 11-bit signed value into the unsigned 8-bit range 0..255.
module sat_u8 (
  input  logic signed [10:0] din_i,
  output logic        [7:0]  dout_o
);
  always_comb begin
    dout_o = din_i[7:0];
    if (din_i[10]) begin
      dout_o = 8'h00;
    end else if (din_i[9:8] != 2'b00) begin
      dout_o = 8'hFF;
    end
  end
endmodule

// File: rtl/ycbcr_rgb565.sv
// Three-stage YCbCr (BT.601 full range) to RGB565 converter, one pixel per cycle.
module ycbcr_rgb565
  import ycbcr_pkg::*;
#(
  parameter int ROUND = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pre_rd_en,
  input  logic [7:0]  img_y,
  input  logic [7:0]  img_cb,
  input  logic [7:0]  img_cr,
  output logic        rd_en_dly,
  output logic [15:0] rgb565_data
);
  localparam logic signed [W_PROD-1:0] K = (ROUND == 1) ? W_PROD'(C_RND) : '0;

  logic                     v1_q, v2_q, v3_q;
  logic signed [9:0]        y_d, y_q;
  logic signed [8:0]        cb_d, cr_d;
  logic signed [W_PROD-1:0] pr_d, pgb_d, pgr_d, pb_d;
  logic signed [W_PROD-1:0] pr_q, pgb_q, pgr_q, pb_q;
  logic signed [W_PROD-1:0] sum_r, sum_g, sum_b, sh_r, sh_g, sh_b;
  logic signed [W_RES-1:0]  r_d, g_d, b_d, r_q, g_q, b_q;
  logic [7:0]               r8, g8, b8;
  logic [15:0]              rgb_d, rgb_q;
  logic                     unused_bits;

  // Stage 1: remove chroma offset and form the four coefficient products.
  always_comb begin
    y_d   = {2'b00, img_y};
    cb_d  = 9'({1'b0, img_cb}) - 9'(C_OFFSET);
    cr_d  = 9'({1'b0, img_cr}) - 9'(C_OFFSET);
    pr_d  = mul_coef(cr_d, C_R_CR);
    pgb_d = mul_coef(cb_d, C_G_CB);
    pgr_d = mul_coef(cr_d, C_G_CR);
    pb_d  = mul_coef(cb_d, C_B_CB);
  end

  // Stage 2: scale back by 256 (arithmetic shift floors; K turns it into rounding).
  always_comb begin
    sum_r = pr_q + K;
    sum_g = pgb_q + pgr_q + K;
    sum_b = pb_q + K;
    sh_r  = sum_r >>> C_SHIFT;
    sh_g  = sum_g >>> C_SHIFT;
    sh_b  = sum_b >>> C_SHIFT;
    r_d   = {y_q[9], y_q} + sh_r[W_RES-1:0];
    g_d   = {y_q[9], y_q} - sh_g[W_RES-1:0];
    b_d   = {y_q[9], y_q} + sh_b[W_RES-1:0];
  end

  sat_u8 u_sat_r (.din_i(r_q), .dout_o(r8));
  sat_u8 u_sat_g (.din_i(g_q), .dout_o(g8));
  sat_u8 u_sat_b (.din_i(b_q), .dout_o(b8));

  assign rgb_d = {r8[7:3], g8[7:2], b8[7:3]};

  assign unused_bits = ^{sh_r[W_PROD-1:W_RES], sh_g[W_PROD-1:W_RES], sh_b[W_PROD-1:W_RES],
                         r8[2:0], g8[1:0], b8[2:0]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      y_q   <= '0;
      pr_q  <= '0;
      pgb_q <= '0;
      pgr_q <= '0;
      pb_q  <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      rgb_q <= '0;
    end else begin
      v1_q <= pre_rd_en;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (pre_rd_en) begin
        y_q   <= y_d;
        pr_q  <= pr_d;
        pgb_q <= pgb_d;
        pgr_q <= pgr_d;
        pb_q  <= pb_d;
      end
      if (v1_q) begin
        r_q <= r_d;
        g_q <= g_d;
        b_q <= b_d;
      end
      // Output holds the last valid pixel through idle cycles.
      if (v2_q) begin
        rgb_q <= rgb_d;
      end
    end
  end

  assign rd_en_dly   = v3_q;
  assign rgb565_data = rgb_q;
endmodule

// File: doc/ycbcr_rgb565.md
YCBCR_RGB565 -- requirements
Module: ycbcr_rgb565

Interface
REQ-001 Parameter: ROUND, default 1, when 1 add 128 before each >>>8 coefficient shift; when 0 truncate (arithmetic floor).
REQ-002 sys_clk  input  1  single clock, all state on rising edge.
REQ-003 sys_rst_n  input  1  asynchronous active-low reset.
REQ-004 pre_rd_en  input  1  input pixel valid, sampled each sys_clk edge.
REQ-005 img_y  input  8  luma, unsigned, full range 0..255.
REQ-006 img_cb  input  8  blue chroma, unsigned, offset 128.
REQ-007 img_cr  input  8  red chroma, unsigned, offset 128.
REQ-008 rd_en_dly  output  1  output pixel valid, pre_rd_en delayed 3 cycles.
REQ-009 rgb565_data  output  16  {R[7:3],G[7:2],B[7:3]} of converted pixel.

Function
REQ-010 Block SHALL implement the inverse of the team's RGB565->YCbCr path, BT.601 full-range, coefficients scaled by 256.
REQ-011 Stage 1 (cycle 1): register Y as 10-bit signed; cb=Cb-128, cr=Cr-128 as 9-bit signed; register products pr=359*cr, pgb=88*cb, pgr=183*cr, pb=454*cb (signed, >=18 bits); register valid v1.
REQ-012 Stage 2 (cycle 2): R'=Y+((pr+K)>>>8), G'=Y-((pgb+pgr+K)>>>8), B'=Y+((pb+K)>>>8), K=128 if ROUND=1 else 0, >>> arithmetic; signed 11-bit results; register v2.
REQ-013 Stage 3 (cycle 3): saturate each of R',G',B' to 0..255 (negative->0, >255->255), pack to rgb565_data, register rd_en_dly<=v2.
REQ-014 Latency SHALL be exactly 3 sys_clk edges from pre_rd_en/data sample to rd_en_dly/rgb565_data.
REQ-015 Throughput SHALL be one pixel per cycle; back-to-back valid pixels SHALL emerge back-to-back in order, no bubbles inserted or removed.
REQ-016 Data registers SHALL advance only when their stage valid is high; with valid low, rgb565_data SHALL hold the last valid pixel.
REQ-017 Valid pipeline (v1,v2,rd_en_dly) SHALL advance every cycle regardless of data.
REQ-018 No backpressure; downstream SHALL accept every rd_en_dly pulse.
REQ-019 Intermediate arithmetic SHALL never overflow for any 8-bit input triple (extreme: cb=cr=-128 or 127).

Reset
REQ-020 On sys_rst_n low, v1, v2, rd_en_dly SHALL clear to 0 and rgb565_data to 16'h0000 immediately (asynchronous).
REQ-021 Stage 1/2 data registers SHALL clear to 0 on reset.
REQ-022 Reset mid-stream SHALL discard all in-flight pixels; no rd_en_dly pulse for pixels sampled before deassertion.
REQ-023 First pixel sampled on the first edge after deassertion SHALL appear 3 cycles later.

Structure
REQ-024 Shared package ycbcr_pkg SHALL hold constants C_R_CR=359, C_G_CB=88, C_G_CR=183, C_B_CB=454, C_OFFSET=128, C_SHIFT=8, C_RND=128, shared with the RGB->YCbCr block.
REQ-025 One sub-module sat_u8 (11-bit signed in, 8-bit unsigned saturated out, combinational) SHALL be instantiated three times in stage 3.

Verification (ROUND=1)
REQ-026 Y=128,Cb=128,Cr=128 single pulse -> rd_en_dly high exactly 3 cycles later, rgb565_data=16'h8410.
REQ-027 Y=255,Cb=128,Cr=128 -> 16'hFFFF; Y=0,Cb=128,Cr=128 -> 16'h0000.
REQ-028 Positive saturation Y=255,Cb=128,Cr=255 -> R=255,G=164,B=255 -> 16'hFD3F.
REQ-029 Negative saturation Y=0,Cb=0,Cr=128 -> R=0,G=44,B clamped 0 -> 16'h0160.
REQ-030 100 random triples with pre_rd_en continuously high, then gapped randomly -> every output matches software model of REQ-011..013 in order, rd_en_dly count equals input count.
REQ-031 Assert sys_rst_n low for 1 cycle with 2 pixels in flight -> rgb565_data=0 at once, no rd_en_dly for those pixels, next pixel after reset converts correctly.
